// File: rtl/mem_access_sequencer.sv
// Memory-stage load/store sequencer: latches one request and drives a handshaked data bus.
// It stalls the pipeline until the slave acks or TIMEOUT wait cycles elapse, then retires in a one-cycle DONE state.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_rw,
  input  logic        mem_size,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        req_size;
  logic [1:0]  req_lane;
  logic        aligned;
  logic        expire;

  assign aligned = ~mem_size | (address[1:0] == 2'b00);
  assign expire  = (cnt == CNT_LAST);
  assign stall   = ((state == IDLE) & mem_enable & ~reset) | (state == WAIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_enable) state_nxt = aligned ? WAIT : DONE;
      WAIT:    if (bus_ack || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_wdata    <= 32'h0;
      bus_be       <= 4'b0000;
      load_data    <= 32'h0;
      load_valid   <= 1'b0;
      access_error <= 1'b0;
      cnt          <= 8'h0;
      req_size     <= 1'b0;
      req_lane     <= 2'b00;
    end else begin
      load_valid   <= 1'b0;
      access_error <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_enable) begin
            if (aligned) begin
              bus_req   <= 1'b1;
              bus_we    <= mem_rw;
              bus_addr  <= {address[31:2], 2'b00};
              bus_be    <= mem_size ? 4'b1111 : (4'b0001 << address[1:0]);
              bus_wdata <= mem_size ? write_data : {4{write_data[7:0]}};
              req_size  <= mem_size;
              req_lane  <= address[1:0];
              cnt       <= 8'h0;
            end else begin
              access_error <= 1'b1;
            end
          end
        end
        WAIT: begin
          // An ack in the expiry cycle wins over the timeout.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              load_valid <= 1'b1;
              load_data  <= req_size ? bus_rdata
                                     : {24'h0, bus_rdata[{req_lane, 3'b000} +: 8]};
            end
          end else if (expire) begin
            bus_req      <= 1'b0;
            access_error <= 1'b1;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
